// File: rtl/obstacle_field.sv
// Multi-obstacle sprite engine: draws every obstacle, waits one frame, erases and
// moves them right-to-left, respawning in a random lane and scoring on each wrap.
module obstacle_field #(
    parameter int         NUM_OBS       = 2,
    parameter int         SIZE          = 4,
    parameter int         X_START       = 160,
    parameter int         SPACING       = 80,
    parameter int         Y_LOW         = 87,
    parameter int         Y_HIGH        = 75,
    parameter int         FRAME_TICKS   = 2000000,
    parameter logic [2:0] COLOUR        = 3'b011,
    parameter int         SPEEDUP_EVERY = 8,
    parameter int         MAX_STEP      = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 go,
    input  logic                 hold,
    output logic [7:0]           out_x,
    output logic [6:0]           out_y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic [7:0]           score,
    output logic [8*NUM_OBS-1:0] obs_x,
    output logic [7*NUM_OBS-1:0] obs_y,
    output logic                 busy
);
    // state | meaning
    // IDLE  | waiting for go
    // DRAW  | plotting every obstacle in COLOUR
    // WAIT  | frame delay, counter frozen while hold is high
    // ERASE | plotting every obstacle in black
    // MOVE  | single-cycle position, score and step update

    localparam int LG = $clog2(SIZE);
    localparam int PW = 2 * LG;
    localparam int KW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
    localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(SIZE * SIZE - 1);
    localparam logic [KW-1:0] OBS_LAST = KW'(NUM_OBS - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_TICKS - 1);

    typedef enum logic [2:0] {S_IDLE, S_DRAW, S_WAIT, S_ERASE, S_MOVE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [KW-1:0] obs_q, obs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    x_q [NUM_OBS];
    logic [7:0]    x_d [NUM_OBS];
    logic [6:0]    y_q [NUM_OBS];
    logic [6:0]    y_d [NUM_OBS];
    logic [7:0]    score_q, score_d;
    logic [7:0]    step_q, step_d;
    logic [3:0]    lfsr_q, lfsr_d;
    logic          last_pix;
    logic [7:0]    cur_x;
    logic [6:0]    cur_y;

    assign last_pix = (pix_q == PIX_LAST) && (obs_q == OBS_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_DRAW;
            S_DRAW:  if (last_pix) state_d = S_WAIT;
            S_WAIT:  if ((cnt_q == '0) && !hold) state_d = S_ERASE;
            S_ERASE: if (last_pix) state_d = S_MOVE;
            S_MOVE:  state_d = S_DRAW;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        int wraps;
        int total;
        int st;
        wraps   = 0;
        total   = 0;
        st      = 0;
        pix_d   = pix_q;
        obs_d   = obs_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        step_d  = step_q;
        lfsr_d  = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        for (int i = 0; i < NUM_OBS; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
        end
        case (state_q)
            S_DRAW, S_ERASE: begin
                if (pix_q == PIX_LAST) begin
                    pix_d = '0;
                    obs_d = (obs_q == OBS_LAST) ? '0 : obs_q + 1'b1;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (!hold) begin
                    cnt_d = (cnt_q == '0) ? CNT_LOAD : cnt_q - 1'b1;
                end
            end
            S_MOVE: begin
                // Step used here was derived from the score left by the previous MOVE.
                for (int i = 0; i < NUM_OBS; i++) begin
                    if (x_q[i] < step_q) begin
                        x_d[i] = 8'(X_START);
                        y_d[i] = lfsr_q[i] ? 7'(Y_HIGH) : 7'(Y_LOW);
                        wraps  = wraps + 1;
                    end else begin
                        x_d[i] = x_q[i] - step_q;
                    end
                end
                total   = int'(score_q) + wraps;
                score_d = (total > 255) ? 8'd255 : 8'(total);
                st      = 1 + int'(score_d) / SPEEDUP_EVERY;
                step_d  = (st > MAX_STEP) ? 8'(MAX_STEP) : 8'(st);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_q   <= '0;
            obs_q   <= '0;
            cnt_q   <= CNT_LOAD;
            score_q <= '0;
            step_q  <= 8'd1;
            lfsr_q  <= 4'b1110;
            for (int i = 0; i < NUM_OBS; i++) begin
                x_q[i] <= 8'(X_START - i * SPACING);
                y_q[i] <= 7'(Y_LOW);
            end
        end else begin
            pix_q   <= pix_d;
            obs_q   <= obs_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            step_q  <= step_d;
            lfsr_q  <= lfsr_d;
            for (int i = 0; i < NUM_OBS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    always_comb begin
        cur_x = x_q[0];
        cur_y = y_q[0];
        for (int i = 1; i < NUM_OBS; i++) begin
            if (obs_q == KW'(i)) begin
                cur_x = x_q[i];
                cur_y = y_q[i];
            end
        end
        plot   = (state_q == S_DRAW) || (state_q == S_ERASE);
        colour = (state_q == S_DRAW) ? COLOUR : 3'b000;
        busy   = (state_q != S_IDLE);
        out_x  = cur_x + 8'(pix_q[LG-1:0]);
        out_y  = cur_y + 7'(pix_q[PW-1:LG]);
    end

    always_comb begin
        for (int i = 0; i < NUM_OBS; i++) begin
            obs_x[8*i +: 8] = x_q[i];
            obs_y[7*i +: 7] = y_q[i];
        end
    end

    assign score = score_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Self-checking bench: two obstacle_field instances (spec-sized and a fast-wrapping one)
// compared cycle by cycle against a frame-level model of positions, lanes and score.
module tb_obstacle_field;
    logic        clock = 1'b0;
    logic        reset;
    logic        go_a = 1'b0, hold_a = 1'b0, go_b = 1'b0, hold_b = 1'b0;
    logic [7:0]  a_out_x, b_out_x, a_score, b_score;
    logic [6:0]  a_out_y, b_out_y;
    logic [2:0]  a_colour, b_colour;
    logic        a_plot, b_plot, a_busy, b_busy;
    logic [15:0] a_obs_x, b_obs_x;
    logic [13:0] a_obs_y, b_obs_y;

    obstacle_field #(.FRAME_TICKS(4)) dut_a (
        .clock(clock), .reset(reset), .go(go_a), .hold(hold_a),
        .out_x(a_out_x), .out_y(a_out_y), .colour(a_colour), .plot(a_plot),
        .score(a_score), .obs_x(a_obs_x), .obs_y(a_obs_y), .busy(a_busy)
    );

    obstacle_field #(.NUM_OBS(2), .SIZE(2), .X_START(8), .SPACING(0), .FRAME_TICKS(1)) dut_b (
        .clock(clock), .reset(reset), .go(go_b), .hold(hold_b),
        .out_x(b_out_x), .out_y(b_out_y), .colour(b_colour), .plot(b_plot),
        .score(b_score), .obs_x(b_obs_x), .obs_y(b_obs_y), .busy(b_busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int m_cyc;
    int m_x [2][2];
    int m_y [2][2];
    int m_score [2];
    int p_xs [2]   = '{160, 8};
    int p_sp [2]   = '{80, 0};
    int p_size [2] = '{4, 2};
    int p_ft [2]   = '{4, 1};
    int sel = 0;

    // clocks seen since reset release; the lane LFSR advances once per clock
    always @(posedge clock or posedge reset) begin
        if (reset) m_cyc <= 0;
        else       m_cyc <= m_cyc + 1;
    end

    logic        s_plot, s_busy;
    logic [2:0]  s_colour;
    logic [7:0]  s_x, s_score;
    logic [6:0]  s_y;
    logic [15:0] s_obs_x;
    logic [13:0] s_obs_y;

    always_comb begin
        if (sel == 0) begin
            s_plot = a_plot; s_busy = a_busy; s_colour = a_colour; s_x = a_out_x;
            s_y = a_out_y; s_score = a_score; s_obs_x = a_obs_x; s_obs_y = a_obs_y;
        end else begin
            s_plot = b_plot; s_busy = b_busy; s_colour = b_colour; s_x = b_out_x;
            s_y = b_out_y; s_score = b_score; s_obs_x = b_obs_x; s_obs_y = b_obs_y;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] lfsr_at(input int n);
        logic [3:0] v = 4'b1110;
        for (int i = 0; i < n; i++) v = {v[2:0], v[3] ^ v[2]};
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_score[d] = 0;
            for (int i = 0; i < 2; i++) begin
                m_x[d][i] = p_xs[d] - i * p_sp[d];
                m_y[d][i] = 87;
            end
        end
    endtask

    task automatic model_move(input int d);
        logic [3:0] r = lfsr_at(m_cyc);
        int step = 1 + m_score[d] / 8;
        int wraps = 0;
        if (step > 4) step = 4;
        for (int i = 0; i < 2; i++) begin
            if (m_x[d][i] < step) begin
                m_x[d][i] = p_xs[d];
                m_y[d][i] = r[i] ? 75 : 87;
                wraps++;
            end else begin
                m_x[d][i] = m_x[d][i] - step;
            end
        end
        m_score[d] = (m_score[d] + wraps > 255) ? 255 : m_score[d] + wraps;
    endtask

    task automatic drive(input logic g, input logic h);
        if (sel == 0) begin go_a = g; hold_a = h; end
        else          begin go_b = g; hold_b = h; end
    endtask

    task automatic check_pos(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_obs_x"}, s_obs_x[8*i +: 8], m_x[sel][i]);
            check({tag, "_obs_y"}, s_obs_y[7*i +: 7], m_y[sel][i]);
        end
        check({tag, "_score"}, s_score, m_score[sel]);
    endtask

    task automatic plot_pass(input int col, input string tag);
        int sz = p_size[sel];
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < sz * sz; p++) begin
                check({tag, "_plot"}, s_plot, 1);
                check({tag, "_colour"}, s_colour, col);
                check({tag, "_x"}, s_x, m_x[sel][k] + p % sz);
                check({tag, "_y"}, s_y, m_y[sel][k] + p / sz);
                drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
                @(negedge clock);
            end
        end
    endtask

    // called at the first DRAW cycle; returns at the first DRAW cycle of the next frame
    task automatic frame(input int hold_n);
        int zeros = 0;
        int cyc = 0;
        logic h;
        plot_pass(3, "draw");
        while (zeros < p_ft[sel]) begin
            check("wait_plot", s_plot, 0);
            check("wait_busy", s_busy, 1);
            if (hold_n > 0) h = (cyc < hold_n);
            else            h = (cyc < 20) && ($urandom_range(0, 2) == 0);
            drive(1'($urandom_range(0, 1)), h);
            if (!h) zeros++;
            cyc++;
            @(negedge clock);
        end
        plot_pass(0, "erase");
        check("move_plot", s_plot, 0);
        check("move_busy", s_busy, 1);
        model_move(sel);
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        @(negedge clock);
        check_pos("move");
    endtask

    initial begin
        int extra = 0;
        reset = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        sel = 0;
        repeat (2) @(negedge clock);
        check("rst_busy", a_busy, 0);
        check("rst_plot", a_plot, 0);
        check("rst_colour", a_colour, 0);
        check_pos("rst");
        reset = 1'b0;
        hold_a = 1'b1;
        @(negedge clock);
        check("idle_busy", a_busy, 0);
        go_a = 1'b1;
        hold_a = 1'b0;
        @(negedge clock);
        go_a = 1'b0;
        check("go_busy", a_busy, 1);
        frame(0);
        frame(10);
        for (int f = 0; f < 4; f++) frame(0);

        repeat (5) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(negedge clock);
        end
        go_a = 1'b0;
        hold_a = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check("mid_rst_plot", a_plot, 0);
        check("mid_rst_busy", a_busy, 0);
        check_pos("mid_rst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        sel = 1;
        go_b = 1'b1;
        @(negedge clock);
        go_b = 1'b0;
        check("b_go_busy", b_busy, 1);
        for (int f = 0; f < 700 && extra < 8; f++) begin
            frame(0);
            if (m_score[1] == 255) extra++;
        end
        check("b_saturated", b_score, 255);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
